param_commit_sched: RTL and testbench

- Schedules host parameter writes into the synapse/neuron/clock-generator datapath so they take effect only on simulation-step boundaries.
- Host writes (address plus 32-bit data assembled from the two 16-bit wire-ins) are queued in a small FIFO.
- On each sim_tick the queued writes are drained into shadow registers, then all changed parameters are committed to the live outputs in a single cycle.
- Replaces the per-trigger asynchronous parameter registers feeding ltp, ltd, p_delta, syn_gain and the clock divider half count.

---
 rtl/param_commit_sched_if.sv | 12 +
 rtl/param_commit_sched.sv | 141 ++++++++++++++
 tb/tb_param_commit_sched.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_commit_sched_if.sv
// Host parameter-write channel: address/data request with valid/ready handshake.
// Latency: none, wires only.
// Backpressure: the slave lowers wr_ready and the master holds its request until accepted.
interface param_commit_sched_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  wr_addr;
   logic [31:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/param_commit_sched.sv
// Purpose: queues host parameter writes and applies them to the live outputs only on sim_tick boundaries.
// Latency: tick in IDLE at cycle T with N queued -> pops end T+1..T+N, COMMIT is T+N+1, values and commit visible at T+N+2.
// Backpressure: wr_ready drops while the DEPTH-entry queue is full; writes are accepted in every FSM state.
module param_commit_sched #(
   parameter int unsigned DEPTH        = 4,
   parameter logic [31:0] HALF_CNT_RST = 32'd1,
   parameter logic [31:0] SYN_GAIN_RST = 32'd1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       sim_tick,
   param_commit_sched_if.slave        wr,
   output logic [31:0]                ltp,
   output logic [31:0]                ltd,
   output logic [31:0]                p_delta,
   output logic [31:0]                syn_gain,
   output logic [31:0]                half_cnt,
   output logic                       commit,
   output logic [$clog2(DEPTH):0]     pending,
   output logic                       busy,
   output logic                       tick_late,
   output logic                       bad_addr
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
   localparam logic [2:0]  A_HALF = 3'd4;

   typedef struct packed {
      logic [2:0]  addr;
      logic [31:0] data;
   } entry_t;

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

   entry_t         mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW:0]    count;
   entry_t         head;
   logic           push;
   logic           pop;

   state_t         state;
   logic [31:0]    shadow [0:4];
   logic [31:0]    live   [0:4];
   logic [4:0]     dirty;

   function automatic logic [31:0] rst_val(input int idx);
      case (idx)
         3:       rst_val = SYN_GAIN_RST;
         4:       rst_val = HALF_CNT_RST;
         default: rst_val = 32'd0;
      endcase
   endfunction

   assign wr.wr_ready = (count != FULL);
   assign push        = wr.wr_valid && wr.wr_ready;
   assign pop         = (state == DRAIN) && (count != '0);
   assign head        = mem[rd_ptr];

   assign pending  = count;
   assign busy     = (state != IDLE);
   assign ltp      = live[0];
   assign ltd      = live[1];
   assign p_delta  = live[2];
   assign syn_gain = live[3];
   assign half_cnt = live[4];

   // Queue storage: entries are written at the tail; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{addr: wr.wr_addr, data: wr.wr_data};
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Step scheduler: drains the queue into shadows on a tick, then copies dirty shadows to live in one cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         commit    <= 1'b0;
         tick_late <= 1'b0;
         bad_addr  <= 1'b0;
         dirty     <= '0;
         for (int i = 0; i < 5; i++) begin
            live[i]   <= rst_val(i);
            shadow[i] <= rst_val(i);
         end
      end else begin
         commit <= 1'b0;
         case (state)
            IDLE: begin
               if (sim_tick) begin
                  if (count != '0)      state <= DRAIN;
                  else if (dirty != '0) state <= COMMIT;
               end
            end
            DRAIN: begin
               if (sim_tick) tick_late <= 1'b1;
               if (pop) begin
                  if (head.addr <= A_HALF) begin
                     // A zero divider half count would stall the clock generator.
                     shadow[head.addr] <= (head.addr == A_HALF && head.data == 32'd0) ? 32'd1 : head.data;
                     dirty[head.addr]  <= 1'b1;
                  end else begin
                     bad_addr <= 1'b1;
                  end
               end
               // Entries arriving during the drain belong to this step as well.
               if (count == (PW + 1)'(1) && !push) state <= COMMIT;
            end
            COMMIT: begin
               if (sim_tick) tick_late <= 1'b1;
               for (int i = 0; i < 5; i++) begin
                  if (dirty[i]) live[i] <= shadow[i];
               end
               dirty  <= '0;
               commit <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_param_commit_sched.sv
// Scoreboard bench for param_commit_sched: expected live values queued per step, checked on every commit pulse.
// Latency: directed checks pin commit timing to tick cycle + entries + 2.
// Backpressure: exercises a full queue with a held write that enters mid-drain.
module tb_param_commit_sched;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        sim_tick;
   logic [31:0] ltp, ltd, p_delta, syn_gain, half_cnt;
   logic        commit;
   logic [2:0]  pending;
   logic        busy, tick_late, bad_addr;

   int checks = 0;
   int errors = 0;
   int commit_cnt = 0;

   typedef struct {
      logic [31:0] ltp;
      logic [31:0] ltd;
      logic [31:0] p_delta;
      logic [31:0] syn_gain;
      logic [31:0] half_cnt;
   } exp_t;
   exp_t exp_q[$];

   param_commit_sched_if wr_if();

   param_commit_sched #(.DEPTH(4), .HALF_CNT_RST(32'd1), .SYN_GAIN_RST(32'd1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sim_tick  (sim_tick),
      .wr        (wr_if),
      .ltp       (ltp),
      .ltd       (ltd),
      .p_delta   (p_delta),
      .syn_gain  (syn_gain),
      .half_cnt  (half_cnt),
      .commit    (commit),
      .pending   (pending),
      .busy      (busy),
      .tick_late (tick_late),
      .bad_addr  (bad_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every commit pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (commit === 1'b1) begin
         commit_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit actual=1 required=0");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_ltp", ltp, e.ltp);
            chk("sb_ltd", ltd, e.ltd);
            chk("sb_p_delta", p_delta, e.p_delta);
            chk("sb_syn_gain", syn_gain, e.syn_gain);
            chk("sb_half_cnt", half_cnt, e.half_cnt);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the edge that accepted the entry.
   task automatic push(input logic [2:0] a, input logic [31:0] d);
      logic rdy;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_addr  = a;
      wr_if.wr_data  = d;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         rdy = wr_if.wr_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         if (k == 49) chk("push_timeout", 32'(rdy), 32'd1);
      end
      wr_if.wr_valid = 1'b0;
   endtask

   // sim_tick high for exactly one cycle (cycle T); returns at posedge+1 of T+1.
   task automatic tick();
      sim_tick = 1'b1;
      @(posedge clk);
      #1;
      sim_tick = 1'b0;
   endtask

   // After tick(): checks pending/busy per drain cycle and the exact commit cycle T+n+2.
   task automatic check_step_timing(input int n);
      for (int k = 1; k <= n + 2; k++) begin
         @(negedge clk);
         if (k <= n + 1) begin
            chk("drain_pending", 32'(pending), 32'(n - k + 1));
            chk("drain_busy", 32'(busy), 32'd1);
         end
         if (k == n + 1) chk("commit_early", 32'(commit), 32'd0);
         if (k == n + 2) chk("commit_cycle", 32'(commit), 32'd1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_commit(input int limit);
      bit seen = 0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (commit === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk("commit_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_vals(input logic [31:0] a, b, c, d, e);
      exp_t x;
      x.ltp = a; x.ltd = b; x.p_delta = c; x.syn_gain = d; x.half_cnt = e;
      exp_q.push_back(x);
   endtask

   initial begin
      reset_n = 1'b0;
      sim_tick = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_addr = 3'd0;
      wr_if.wr_data = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset values.
      @(negedge clk);
      chk("rst_ltp", ltp, 32'd0);
      chk("rst_ltd", ltd, 32'd0);
      chk("rst_p_delta", p_delta, 32'd0);
      chk("rst_syn_gain", syn_gain, 32'd1);
      chk("rst_half_cnt", half_cnt, 32'd1);
      chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flags", {30'd0, tick_late, bad_addr}, 32'd0);
      @(posedge clk);
      #1;

      // Single write takes effect only after a tick.
      push(3'd3, 32'h0000_0010);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("deferred_syn_gain", syn_gain, 32'd1);
      chk("no_commit_without_tick", 32'(commit_cnt), 32'd0);
      chk("held_pending", 32'(pending), 32'd1);
      @(posedge clk);
      #1;
      expect_vals(32'd0, 32'd0, 32'd0, 32'd16, 32'd1);
      tick();
      check_step_timing(1);

      // Multi-write: last write wins, half_cnt zero clamps to one.
      push(3'd0, 32'd5);
      push(3'd1, 32'd7);
      push(3'd0, 32'd9);
      push(3'd4, 32'd0);
      expect_vals(32'd9, 32'd7, 32'd0, 32'd16, 32'd1);
      tick();
      check_step_timing(4);
      chk("single_commit_multi", 32'(commit_cnt), 32'd2);

      // Backpressure: fifth write waits on a full queue and joins the running drain.
      push(3'd0, 32'd11);
      push(3'd1, 32'd22);
      push(3'd2, 32'd33);
      push(3'd3, 32'd44);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_addr  = 3'd4;
      wr_if.wr_data  = 32'd55;
      @(negedge clk);
      chk("full_wr_ready", 32'(wr_if.wr_ready), 32'd0);
      chk("full_pending", 32'(pending), 32'd4);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("held_full_pending", 32'(pending), 32'd4);
      @(posedge clk);
      #1;
      expect_vals(32'd11, 32'd22, 32'd33, 32'd44, 32'd55);
      tick();
      for (int k = 0; k < 20; k++) begin
         logic rdy;
         @(negedge clk);
         rdy = wr_if.wr_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
      end
      wr_if.wr_valid = 1'b0;
      @(negedge clk);
      chk("fifth_in_drain_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      wait_commit(20);
      chk("pending_after_bp", 32'(pending), 32'd0);

      // Late tick and invalid address.
      chk("pre_bad_addr", 32'(bad_addr), 32'd0);
      chk("pre_tick_late", 32'(tick_late), 32'd0);
      push(3'd6, 32'd1);
      push(3'd2, 32'd3);
      expect_vals(32'd11, 32'd22, 32'd3, 32'd44, 32'd55);
      tick();
      tick();
      wait_commit(20);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("bad_addr_set", 32'(bad_addr), 32'd1);
      chk("tick_late_set", 32'(tick_late), 32'd1);
      chk("one_commit_late", 32'(commit_cnt), 32'd4);
      @(posedge clk);
      #1;

      // Reset during the second drain cycle aborts the step.
      push(3'd0, 32'd100);
      push(3'd1, 32'd200);
      push(3'd3, 32'd300);
      tick();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_ltp", ltp, 32'd0);
      chk("mid_rst_ltd", ltd, 32'd0);
      chk("mid_rst_p_delta", p_delta, 32'd0);
      chk("mid_rst_syn_gain", syn_gain, 32'd1);
      chk("mid_rst_half_cnt", half_cnt, 32'd1);
      chk("mid_rst_pending", 32'(pending), 32'd0);
      chk("mid_rst_flags", {29'd0, busy, tick_late, bad_addr}, 32'd0);
      @(posedge clk);
      #1;

      // Tick with nothing queued and nothing dirty produces no commit.
      tick();
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("idle_tick_no_commit", 32'(commit_cnt), 32'd4);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end
endmodule
